// File: rtl/uart_rx_if.sv
// uart_rx_if: one-entry receive holding register handshake.
// master drives rx_data/rx_valid, slave returns rx_ready.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver with mid-bit sampling.
// Ports: clk, rst_n, rx (async line), rx_if (data/valid/ready), frame_err, overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx,
  uart_rx_if.master rx_if,
  output logic      frame_err,
  output logic      overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state_q;
  logic                 meta_q;
  logic                 rxs_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] sh_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign frame_err      = ferr_q;
  assign overrun        = ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      meta_q <= rx;
      rxs_q  <= meta_q;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      cnt_q  <= cnt_q + 1'b1;

      if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rxs_q) begin
            state_q <= START;
          end
        end
        START: begin
          // Mid start bit: a high line here was a glitch.
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rxs_q ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_q == BIT_M1) begin
            cnt_q <= '0;
            // LSB arrives first, so shift in from the top.
            sh_q  <= {rxs_q, sh_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (cnt_q == BIT_M1) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= IDLE;
              // A same-cycle accept frees the slot.
              if (!valid_q || rx_if.rx_ready) begin
                data_q  <= sh_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          // Hold off until a break releases the line.
          cnt_q <= '0;
          if (rxs_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the receive-side counterpart of the baud generator path. It samples an asynchronous serial line, detects start bits, and recovers LSB-first data frames (1 start, DATA_BITS data, 1 stop, no parity) using its own bit-period counter that is re-aligned on every start edge. Each frame is delivered through a one-entry holding register with a valid/ready handshake. Framing and overrun errors are reported as single-cycle pulses.

## Interface
- CLKS_PER_BIT, 87, clock cycles per bit (100 MHz / 115200); legal range ≥ 4
- DATA_BITS, 8, data bits per frame; legal range 5–8
- clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- rx  input  1  serial line, asynchronous to clk, idle high
- rx_data  output  DATA_BITS  received byte from the holding register; reset 0
- rx_valid  output  1  holding register full; reset 0
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low; reset 0
- overrun  output  1  one-cycle pulse when a good frame is dropped because the holding register is full; reset 0

## Operation
- Synchronizer: two flops on rx, both reset to 1. All decisions use the second flop output, rx_s.
- HALF = CLKS_PER_BIT/2, integer division (87 → 43).
- Bit counter cnt is $clog2(CLKS_PER_BIT) bits wide and cleared on every state change. Bit index idx counts 0..DATA_BITS-1.
- States (reset → IDLE):
  - IDLE: when rx_s == 0, go to START.
  - START: when cnt == HALF-1, check rx_s.
    - rx_s == 0: go to DATA with idx = 0.
    - rx_s == 1: glitch; go to IDLE with no output.
  - DATA: when cnt == CLKS_PER_BIT-1, shift rx_s in LSB-first (bit idx of the frame).
    - If idx == DATA_BITS-1, go to STOP; otherwise increment idx.
  - STOP: when cnt == CLKS_PER_BIT-1, check rx_s.
    - rx_s == 1: deliver the frame (see below), then go to IDLE.
    - rx_s == 0: pulse frame_err, discard the frame, go to WAIT_HIGH.
  - WAIT_HIGH: when rx_s == 1, go to IDLE. This prevents a break or held-low line from retriggering reception.
- Delivery, at the stop-sample cycle:
  - If rx_valid == 0, or (rx_valid && rx_ready) in that same cycle: load rx_data and keep or set rx_valid = 1.
  - Otherwise: pulse overrun. rx_data and rx_valid stay unchanged; the new frame is lost.
- Handshake:
  - rx_valid clears on the cycle after rx_valid && rx_ready, unless a delivery occurs in that same cycle.
  - rx_data stays stable while rx_valid is high and not accepted.
- frame_err and overrun are never asserted together; each is high for exactly one cycle per event.
- Reset mid-frame: everything returns to reset values immediately, and the partial frame is lost. After reset release, a frame is received only if its start edge is seen in IDLE.

## Timing
- Pin to rx_s: 2 cycles.
- Let t0 be the clock edge at which IDLE sees rx_s == 0.
  - START → DATA at edge t0+HALF.
  - Data bit i is sampled at edge t0+HALF+(i+1)·CLKS_PER_BIT.
  - The stop bit is sampled at edge t0+HALF+(DATA_BITS+1)·CLKS_PER_BIT.
  - rx_valid, frame_err and overrun become visible immediately after the stop-sample edge.
- For CLKS_PER_BIT = 87, DATA_BITS = 8: stop sample at t0+826.
- The receiver re-enters IDLE at mid-stop-bit, so back-to-back frames with no idle gap are received.
- Tolerated baud mismatch is roughly ±4% cumulative over 10 bits; this is not checked by the design.

## Test plan
- CLKS_PER_BIT = 16, rx_ready = 1, send 0x55 with ideal timing. Required: rx_data = 0x55 and rx_valid pulses for 1 cycle, exactly 8+9·16 = 152 edges after t0. frame_err and overrun stay 0.
- Send 0xA5 then 0x3C back-to-back with no idle bits, rx_ready = 1. Required: two deliveries, 0xA5 then 0x3C, 160 cycles apart, and no errors.
- Drive rx low for 5 cycles, then return it high. Required: no rx_valid and no frame_err; the FSM is back in IDLE; a following 0x81 is received correctly.
- Send 0x12 with the stop bit driven 0, then hold rx low for 3 bit times, then raise it and send 0x34. Required: one frame_err pulse, no delivery of 0x12, no retrigger while the line is low, then rx_data = 0x34.
- Hold rx_ready = 0 and send 0x11 then 0x22. Required: rx_valid = 1 with 0x11, one overrun pulse at the second stop sample, rx_data still 0x11. Then raise rx_ready for 1 cycle: rx_valid drops to 0.
- Assert rst_n = 0 midway through the data bits of 0xF0, then release it with the line idle. Required: all outputs read 0 during reset, no delivery of 0xF0, and a following 0x0F is received correctly.
